// File: rtl/seg_scan2.sv
// Two-digit multiplexed 7-segment scanner with anti-ghost blanking and
// frame-synchronous input latching so the display never tears mid-frame.
module seg_scan2 #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig_one,
  input  logic [3:0] dig_two,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {B0, S0, B1, S1} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [3:0]     lat_one, lat_two;
  logic           lat_blank;
  logic           slot_end, blank_end, frame_end;
  logic [6:0]     seg_d;
  logic [1:0]     an_d;

  assign slot_end  = (cnt == SLOT_LAST);
  assign blank_end = (cnt == BLANK_LAST);
  assign frame_end = (state == S1) && slot_end;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments; the async reset
  // is in the sensitivity list so it acts without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= B0;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      B0: if (blank_end) state_nx = S0;
      S0: if (slot_end)  state_nx = B1;
      B1: if (blank_end) state_nx = S1;
      S1: if (slot_end)  state_nx = B0;
    endcase
  end

  always_comb begin
    an_d  = 2'b11;
    seg_d = SEG_OFF;
    unique case (state)
      B0, B1: begin
        an_d  = 2'b11;
        seg_d = SEG_OFF;
      end
      S0: begin
        an_d  = 2'b10;
        seg_d = decode(lat_one);
      end
      S1: begin
        if (!(lat_blank && lat_two == 4'd0)) begin
          an_d  = 2'b01;
          seg_d = decode(lat_two);
        end
      end
    endcase
  end

  // The slot counter spans a blank phase plus its show phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (slot_end) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  // Inputs are captured only at the frame boundary and held for the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_one    <= 4'd0;
      lat_two    <= 4'd0;
      lat_blank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        lat_one   <= dig_one;
        lat_two   <= dig_two;
        lat_blank <= blank_lead;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 2'b11;
      seg <= SEG_OFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan2.sv
// Self-checking bench for seg_scan2: a frame-position model checked every
// cycle, plus literal expectations at hand-picked points of each scenario.
module tb_seg_scan2;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 2 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dig_one = 4'd3;
  logic [3:0] dig_two = 4'd5;
  logic       blank_lead = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  // Model state: k counts clk edges since reset release.
  int         k = 0;
  logic [3:0] m_one = 4'd0, m_two = 4'd0;
  logic       m_bl = 1'b0;
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_an = 2'b11;
  logic       exp_fd = 1'b0;

  seg_scan2 #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .dig_one    (dig_one),
    .dig_two    (dig_two),
    .blank_lead (blank_lead),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0111111;
    return tbl[v];
  endfunction

  // Display content for a frame position: {an, seg}.
  function automatic logic [8:0] model_out(input int pos, input logic [3:0] one,
                                           input logic [3:0] two, input logic bl);
    int slot, off;
    slot = pos / RD;
    off  = pos % RD;
    if (off < BC)                         return {2'b11, 7'h7F};
    if (slot == 0)                        return {2'b10, glyph(one)};
    if (bl && two == 4'd0)                return {2'b11, 7'h7F};
    return {2'b01, glyph(two)};
  endfunction

  // Outputs after edge k show position k-1 with the values latched before edge k.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= 0;
      m_one   <= 4'd0;
      m_two   <= 4'd0;
      m_bl    <= 1'b0;
      exp_seg <= 7'h7F;
      exp_an  <= 2'b11;
      exp_fd  <= 1'b0;
    end else begin
      k <= k + 1;
      {exp_an, exp_seg} <= model_out(k % FRAME, m_one, m_two, m_bl);
      exp_fd <= ((k + 1) % FRAME == 0);
      if ((k + 1) % FRAME == 0) begin
        m_one <= dig_one;
        m_two <= dig_two;
        m_bl  <= blank_lead;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", name, $time, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_an", 32'(an), 32'(exp_an));
      check("model_fd", 32'(frame_done), 32'(exp_fd));
      check("an_not_both_low", 32'(an != 2'b00), 32'd1);
    end
  end

  task automatic goto(input int n);
    int guard = 0;
    while (k < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (k != n) check("goto_edge", 32'(k), 32'(n));
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3 * FRAME);
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic lit(input string name, input logic [1:0] e_an, input logic [6:0] e_seg);
    check({name, "_an"}, 32'(an), 32'(e_an));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    en = 1'b1;
    lit("reset", 2'b11, 7'h7F);
    check("reset_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // First frame shows reset-latched 00 regardless of inputs 3/5.
    goto(1);  check("no_fd_first_b0", 32'(frame_done), 32'd0);
    goto(3);  lit("first_s0_zero", 2'b10, 7'b1000000);
    goto(11); lit("first_s1_zero", 2'b01, 7'b1000000);
    goto(16); check("first_latch_fd", 32'(frame_done), 32'd1);

    // Scan 3/5.
    goto(20); lit("scan_s0", 2'b10, 7'b0110000);
    goto(28); lit("scan_s1", 2'b01, 7'b0010010);
    dig_one = 4'd7; dig_two = 4'd0; blank_lead = 1'b1;

    // Leading-zero blanking.
    goto(36); lit("lz_s0", 2'b10, 7'b1111000);
    goto(44); lit("lz_s1", 2'b11, 7'h7F);
    dig_one = 4'd3; dig_two = 4'd5; blank_lead = 1'b0;

    // Tearing: change mid-S0, current frame keeps 3.
    goto(52); dig_one = 4'd4;
    goto(54); lit("tear_hold", 2'b10, 7'b0110000);
    goto(68); lit("tear_next", 2'b10, 7'b0011001);

    // Invalid BCD shows a dash.
    dig_one = 4'd12;
    goto(84); lit("dash", 2'b10, 7'b0111111);

    // Async reset mid-S1, between edges.
    goto(92); lit("pre_rst_s1", 2'b01, 7'b0010010);
    dig_one = 4'd6; dig_two = 4'd0; blank_lead = 1'b1;
    #2 rst = 1'b1;
    #1;
    lit("async_rst", 2'b11, 7'h7F);
    check("async_rst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    goto(3);  lit("post_rst_s0", 2'b10, 7'b1000000);
    goto(11); lit("post_rst_s1", 2'b01, 7'b1000000);
    goto(15); check("post_rst_no_fd", 32'(frame_done), 32'd0);

    // Sweep all digits, one value pair per frame.
    blank_lead = 1'b0;
    for (int v = 0; v < 10; v++) begin
      dig_one = 4'(v);
      dig_two = 4'(9 - v);
      wait_fd();
    end
    wait_fd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan2.md
SEG_SCAN2 -- requirements
Module: seg_scan2

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit slot; legal range 4..2^20.
REQ-002 The module SHALL have parameter BLANK_CYC, default 500, meaning anti-ghost blank cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dig_one  input  4  BCD value for the right digit, from the upstream counter.
REQ-006 dig_two  input  4  BCD value for the left digit, from the upstream counter.
REQ-007 blank_lead  input  1  1 = suppress the left digit when its latched value is 0.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 an  output  2  digit enables, active-low, registered; an[0] = right, an[1] = left.
REQ-010 frame_done  output  1  one-cycle pulse on the cycle new inputs are latched.

Function
REQ-011 The FSM SHALL have states B0, S0, B1 and S1, sequenced B0->S0->B1->S1->B0 with no other transitions.
REQ-012 The slot counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-013 Bx->Sx SHALL occur when the counter reaches BLANK_CYC-1.
REQ-014 Sx->next Bx SHALL occur when the counter reaches REFRESH_DIV-1.
REQ-015 Each B state SHALL therefore last BLANK_CYC cycles, each S state REFRESH_DIV-BLANK_CYC cycles, and a frame 2*REFRESH_DIV cycles.
REQ-016 dig_one, dig_two and blank_lead SHALL be latched only on the S1->B0 transition.
REQ-017 The latched values SHALL be held constant for the whole frame, so no display tearing occurs when inputs change mid-frame.
REQ-018 frame_done SHALL be 1 for exactly the cycle after the S1->B0 transition edge, i.e. the first B0 cycle, and 0 otherwise.
REQ-019 In B0 and B1, an SHALL be 2'b11 and seg SHALL be 7'h7F.
REQ-020 In S0, an SHALL be 2'b10 and seg SHALL be the decode of latched dig_one.
REQ-021 In S1, an SHALL be 2'b01 and seg SHALL be the decode of latched dig_two.
REQ-022 Exception to REQ-021: if latched blank_lead=1 and latched dig_two=0, an SHALL be 2'b11 and seg SHALL be 7'h7F.
REQ-023 seg and an SHALL be registered so they reflect the state one cycle after that state is entered; there SHALL be no combinational path from inputs to outputs.
REQ-024 Decode values SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 Input values 10..15 SHALL decode to a dash, 7'b0111111 (segment g only).
REQ-026 The right digit SHALL never be leading-zero blanked.
REQ-027 At no cycle SHALL both an bits be 0.
REQ-028 Counter widths SHALL be sized from REFRESH_DIV and SHALL never overflow before wrap.

Reset
REQ-029 While rst=1, the block SHALL hold: state=B0, counter=0, latched digits=0, latched blank_lead=0, an=2'b11, seg=7'h7F, frame_done=0.
REQ-030 Assertion of rst mid-frame SHALL take effect immediately, without waiting for a clk edge.
REQ-031 After rst deasserts, the first frame SHALL display the reset latched values, 00 with no blanking.
REQ-032 frame_done SHALL NOT pulse for that first B0 entry out of reset.
REQ-033 The first input latch after reset SHALL occur at the first S1->B0 transition, 2*REFRESH_DIV cycles after the first active clk edge.

Verification
REQ-034 Bench parameters SHALL be REFRESH_DIV=8, BLANK_CYC=2.
REQ-035 Scenario scan: dig_one=3, dig_two=5, blank_lead=0 -> per 16-cycle frame: 2 cycles an=11/seg=7F, 6 cycles an=10/seg=0110000, 2 cycles blank, 6 cycles an=01/seg=0010010.
REQ-036 Scenario leading zero: dig_two=0, dig_one=7, blank_lead=1 -> S1 slot shows an=11/seg=7F; S0 slot shows an=10/seg=1111000.
REQ-037 Scenario tearing: change dig_one 3->4 during S0 -> the current frame still shows 3; the next frame shows 4; frame_done pulses once per 16 cycles.
REQ-038 Scenario invalid BCD: dig_one=12 -> S0 shows seg=0111111.
REQ-039 Scenario async reset: assert rst mid-S1 between clk edges -> an=11 and seg=7F immediately; after release, the frame shows 00 and frame_done is first seen 16 cycles later.
REQ-040 Scenario all values: sweep dig_one/dig_two through 0..9 in sync with frame_done -> seg matches the REQ-024 table; the an one-hot-low invariant (REQ-027) holds every cycle.
